bp_table_ctrl: RTL and testbench

Controller that owns the 32-entry branch history table of 2-bit hysteresis counters and shares its single access slot between the fetch-stage lookup and the execute-stage resolution update. Lookups get a registered prediction one cycle after acceptance. Updates are buffered in a small queue and drained into the table when the slot is free. After reset, an init sequencer clears the table, and a mispredict pulse is raised for each accepted update whose prediction disagreed with the outcome.

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/bp_upd_fifo.sv | 73 +++++++
 rtl/bp_table_ctrl.sv | 152 +++++++++++++++
 tb/tb_bp_table_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch history table controller.
//   SNT/WNT/WT/ST : 2-bit hysteresis counter encodings
//   bp_state_e    : controller FSM states (INIT clears the table, RUN serves traffic)
//   bp_next       : counter transition for a resolved branch outcome
//   bp_pred       : taken prediction from a counter
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Asymmetric hysteresis: a taken outcome from WNT jumps straight to ST, and a
  // not-taken outcome from WT falls straight to SNT.
  function automatic logic [1:0] bp_next(input logic [1:0] counter, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      case (counter)
        SNT:     nxt = WNT;
        WNT:     nxt = ST;
        WT:      nxt = ST;
        ST:      nxt = ST;
        default: nxt = SNT;
      endcase
    end else begin
      case (counter)
        SNT:     nxt = SNT;
        WNT:     nxt = SNT;
        WT:      nxt = SNT;
        ST:      nxt = WT;
        default: nxt = SNT;
      endcase
    end
    return nxt;
  endfunction

  function automatic logic bp_pred(input logic [1:0] counter);
    return counter[1];
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo -- shift-register FIFO holding resolved-branch updates.
// Entry 0 is always the head, so entries[] is presented in FIFO order.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data     : enqueue {index, taken}; ignored when full unless popping
//   pop                 : remove the head; ignored when empty
//   full, empty, count  : occupancy status
//   entries             : all slots, head first; slots at or beyond count are stale
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int QDEPTH = 2,
  parameter int CW     = $clog2(QDEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [IDX_W:0]               push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [CW-1:0]                count,
  output logic [QDEPTH-1:0][IDX_W:0]   entries
);

  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [QDEPTH-1:0][IDX_W:0] mem, mem_nxt;
  logic [CW-1:0]              cnt_q, cnt_pop, cnt_nxt;
  logic                       do_pop, do_push;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign entries = mem;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next contents: shift out the head on pop, then write the new entry behind the survivors.
  always_comb begin
    mem_nxt = mem;
    if (do_pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        mem_nxt[i] = mem[i + 1];
      end
      mem_nxt[QDEPTH-1] = '0;
      cnt_pop = cnt_q - CW'(1);
    end else begin
      cnt_pop = cnt_q;
    end
    if (do_push) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_nxt[i] = (CW'(i) == cnt_pop) ? push_data : mem_nxt[i];
      end
      cnt_nxt = cnt_pop + CW'(1);
    end else begin
      cnt_nxt = cnt_pop;
    end
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      cnt_q <= '0;
    end else begin
      mem   <= mem_nxt;
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl -- owner of the 2**IDX_W-entry branch history table.
// One table access per cycle, arbitrated: drain when the update queue is full,
// else a fetch lookup, else drain when the queue holds anything.
// Build option: define BP_TABLE_CTRL_FWD_EN to let lookups see queued updates
// (plus one enqueued in the same cycle, applied last); otherwise lookups read
// the table only.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   lk_valid, lk_pc, lk_ready     : fetch lookup handshake; index = pc[IDX_W+1:2]
//   lk_pred_valid, lk_pred        : registered prediction, one cycle after acceptance
//   up_valid, up_pc, up_taken,
//   up_pred, up_ready             : execute resolution handshake
//   mispredict                    : pulse the cycle after an accepted wrong prediction
//   init_done                     : table cleared after reset
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W  = 5,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        lk_ready,
  output logic        lk_pred_valid,
  output logic        lk_pred,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_taken,
  input  logic        up_pred,
  output logic        up_ready,
  output logic        mispredict,
  output logic        init_done
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int CW    = $clog2(QDEPTH + 1);

  logic [1:0]                 bht [DEPTH];
  bp_state_e                  state;
  logic [IDX_W-1:0]           init_cnt;
  logic [IDX_W-1:0]           lk_idx, up_idx, head_idx;
  logic                       head_taken;
  logic                       q_full, q_empty;
  logic [CW-1:0]              q_count;
  logic [QDEPTH-1:0][IDX_W:0] q_entries;
  logic                       run, lk_acc, up_acc, drain;
  logic [1:0]                 lk_ctr;
  logic                       unused_bits;

  assign lk_idx     = lk_pc[IDX_W+1:2];
  assign up_idx     = up_pc[IDX_W+1:2];
  assign head_idx   = q_entries[0][IDX_W:1];
  assign head_taken = q_entries[0][0];

  assign run      = (state == RUN);
  assign lk_ready = run && !q_full;
  assign up_ready = run && !q_full;
  assign lk_acc   = lk_valid && lk_ready;
  assign up_acc   = up_valid && up_ready;
  // A full queue steals the slot; otherwise an idle fetch side lets the head drain.
  assign drain    = run && (q_full || (!lk_valid && !q_empty));

  bp_upd_fifo #(
    .IDX_W  (IDX_W),
    .QDEPTH (QDEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (up_acc),
    .push_data ({up_idx, up_taken}),
    .pop       (drain),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .entries   (q_entries)
  );

  // Counter seen by a lookup, optionally with pending updates folded in oldest first.
  always_comb begin
    lk_ctr = bht[lk_idx];
`ifdef BP_TABLE_CTRL_FWD_EN
    for (int i = 0; i < QDEPTH; i++) begin
      if ((CW'(i) < q_count) && (q_entries[i][IDX_W:1] == lk_idx)) begin
        lk_ctr = bp_next(lk_ctr, q_entries[i][0]);
      end else begin
        lk_ctr = lk_ctr;
      end
    end
    if (up_acc && (up_idx == lk_idx)) begin
      lk_ctr = bp_next(lk_ctr, up_taken);
    end else begin
      lk_ctr = lk_ctr;
    end
`endif
  end

`ifdef BP_TABLE_CTRL_FWD_EN
  assign unused_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};
`else
  assign unused_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0],
                         q_count, q_entries};
`endif

  // Table write port: sequential clearing during INIT, queue drains in RUN.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      bht[init_cnt] <= SNT;
    end else if (drain) begin
      bht[head_idx] <= bp_next(bht[head_idx], head_taken);
    end
  end

  // Controller FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      init_cnt      <= '0;
      init_done     <= 1'b0;
      lk_pred_valid <= 1'b0;
      lk_pred       <= 1'b0;
      mispredict    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + IDX_W'(1);
          if (init_cnt == {IDX_W{1'b1}}) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            state     <= INIT;
            init_done <= 1'b0;
          end
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          init_done <= 1'b0;
        end
      endcase
      lk_pred_valid <= lk_acc;
      lk_pred       <= lk_acc ? bp_pred(lk_ctr) : 1'b0;
      mispredict    <= up_acc && (up_taken != up_pred);
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl: constant vector table, hand sequences
// for the multi-cycle corners, and random traffic against a behavioural model.
module tb_bp_table_ctrl;

  localparam int IDX_W  = 5;
  localparam int QDEPTH = 2;
  localparam int DEPTH  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid, lk_ready, lk_pred_valid, lk_pred;
  logic [31:0] lk_pc;
  logic        up_valid, up_taken, up_pred, up_ready, mispredict, init_done;
  logic [31:0] up_pc;

  always #5 clk = ~clk;

  bp_table_ctrl #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .lk_valid      (lk_valid),
    .lk_pc         (lk_pc),
    .lk_ready      (lk_ready),
    .lk_pred_valid (lk_pred_valid),
    .lk_pred       (lk_pred),
    .up_valid      (up_valid),
    .up_pc         (up_pc),
    .up_taken      (up_taken),
    .up_pred       (up_pred),
    .up_ready      (up_ready),
    .mispredict    (mispredict),
    .init_done     (init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counters as integers 0..3, pending updates as a queue.
  typedef struct { int idx; bit taken; } upd_t;
  int   m_tab [DEPTH];
  upd_t m_q [$];
  bit   m_run;
  int   m_init_cnt;

  logic r, pv, pd, ms;

  typedef struct {
    logic lv; logic [31:0] lpc; logic uv; logic [31:0] upc; logic ut; logic upr;
    logic e_ready; logic e_pv; logic e_pred; logic e_mis;
  } vec_t;
  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_next(input int c, input bit t);
    if (t) return (c == 0) ? 1 : 3;
    return (c == 3) ? 2 : 0;
  endfunction

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd31);
  endfunction

  function automatic vec_t mk(input logic lv, input logic [31:0] lpc, input logic uv,
                              input logic [31:0] upc, input logic ut, input logic upr,
                              input logic er, input logic epv, input logic ep, input logic em);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.upr = upr;
    v.e_ready = er; v.e_pv = epv; v.e_pred = ep; v.e_mis = em;
    return v;
  endfunction

  // One clock cycle: drive, check handshakes at negedge, advance model, check results after edge.
  task automatic do_cycle(input logic lv, input logic [31:0] lpc, input logic uv,
                          input logic [31:0] upc, input logic ut, input logic upr,
                          output logic o_ready, output logic o_pv, output logic o_pred,
                          output logic o_mis);
    bit   exp_ready, la, ua;
    int   li, ui, v;
    upd_t e;
    lk_valid = lv; lk_pc = lpc; up_valid = uv; up_pc = upc; up_taken = ut; up_pred = upr;
    @(negedge clk);
    exp_ready = m_run && (m_q.size() < QDEPTH);
    check1("lk_ready", lk_ready, exp_ready);
    check1("up_ready", up_ready, exp_ready);
    check1("init_done", init_done, m_run);
    o_ready = lk_ready;
    la = lv && exp_ready;
    ua = uv && exp_ready;
    li = pc_idx(lpc);
    ui = pc_idx(upc);
    v  = m_tab[li];
`ifdef BP_TABLE_CTRL_FWD_EN
    foreach (m_q[k]) if (m_q[k].idx == li) v = m_next(v, m_q[k].taken);
    if (ua && (ui == li)) v = m_next(v, ut);
`endif
    if (m_run) begin
      if ((m_q.size() == QDEPTH) || (!lv && (m_q.size() > 0))) begin
        e = m_q.pop_front();
        m_tab[e.idx] = m_next(m_tab[e.idx], e.taken);
      end
      if (ua) m_q.push_back('{idx: ui, taken: ut});
    end else begin
      m_init_cnt++;
      if (m_init_cnt == DEPTH) begin
        m_run = 1'b1;
        foreach (m_tab[k]) m_tab[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    check1("lk_pred_valid", lk_pred_valid, la);
    if (la) check1("lk_pred", lk_pred, (v >= 2));
    check1("mispredict", mispredict, ua && (ut != upr));
    o_pv = lk_pred_valid; o_pred = lk_pred; o_mis = mispredict;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
  endtask

  task automatic release_reset();
    m_q.delete(); m_run = 1'b0; m_init_cnt = 0;
    lk_valid = 1'b0; lk_pc = 32'h0; up_valid = 1'b0; up_pc = 32'h0;
    up_taken = 1'b0; up_pred = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          zeros, li, ui;
    logic [7:0]  rdy_hist;
    logic        lv, uv, ut, upr;
    logic [31:0] lpc, upc;

    // Index-16 training sequence and mispredict pulses, all after a clean init.
    vecs[0]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    rst = 1'b1;
    release_reset();

    // Init window: model expects init_done low for 32 cycles.
    idle(DEPTH);
    check1("init_done_at_32", init_done, 1'b1);

    // Every index reads not-taken after init.
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
      check1($sformatf("sweep_pred_%0d", i), pd, 1'b0);
    end

    for (int i = 0; i < NV; i++) begin
      do_cycle(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].upr,
               r, pv, pd, ms);
      check1($sformatf("vec%0d_lk_ready", i), r, vecs[i].e_ready);
      check1($sformatf("vec%0d_pred_valid", i), pv, vecs[i].e_pv);
      if (vecs[i].e_pv) check1($sformatf("vec%0d_pred", i), pd, vecs[i].e_pred);
      check1($sformatf("vec%0d_mispredict", i), ms, vecs[i].e_mis);
    end

    // Continuous lookups with two updates: exactly one lk_ready gap, at the third cycle.
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, 32'h24, (i < 2), 32'h14, 1'b1, 1'b1, r, pv, pd, ms);
      rdy_hist[i] = r;
      if (!r) zeros++;
    end
    checkn("cont_ready_gaps", zeros, 1);
    check1("cont_ready_gap_cycle", rdy_hist[2], 1'b0);
    idle(3);
    do_cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
    check1("cont_final_pred", pd, 1'b1);

    // Lookups of index 3 while taken updates to it are still queued.
    do_cycle(1'b1, 32'h100, 1'b1, 32'h0C, 1'b1, 1'b0, r, pv, pd, ms);
    do_cycle(1'b1, 32'h0C, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
    check1("fwd_one_queued", pd, 1'b0);
    do_cycle(1'b1, 32'h0C, 1'b1, 32'h0C, 1'b1, 1'b0, r, pv, pd, ms);
`ifdef BP_TABLE_CTRL_FWD_EN
    check1("fwd_two_queued", pd, 1'b1);
`else
    check1("fwd_two_queued", pd, 1'b0);
`endif
    idle(3);
    do_cycle(1'b1, 32'h0C, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
    check1("fwd_drained_pred", pd, 1'b1);

    // Reset with two updates queued behind lookups of a strongly-taken entry.
    do_cycle(1'b1, 32'h14, 1'b1, 32'h1C, 1'b1, 1'b0, r, pv, pd, ms);
    do_cycle(1'b1, 32'h14, 1'b1, 32'h1C, 1'b1, 1'b0, r, pv, pd, ms);
    rst = 1'b1;
    #1;
    check1("rst_lk_ready", lk_ready, 1'b0);
    check1("rst_up_ready", up_ready, 1'b0);
    check1("rst_lk_pred_valid", lk_pred_valid, 1'b0);
    check1("rst_lk_pred", lk_pred, 1'b0);
    check1("rst_mispredict", mispredict, 1'b0);
    check1("rst_init_done", init_done, 1'b0);
    release_reset();
    idle(DEPTH);
    do_cycle(1'b1, 32'h1C, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
    check1("rst_dropped_updates", pd, 1'b0);
    do_cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);
    check1("rst_reinit_entry5", pd, 1'b0);

    // Random traffic on a few colliding indices, with junk in the ignored PC bits.
    for (int i = 0; i < 300; i++) begin
      lv  = ($urandom_range(0, 99) < 60);
      uv  = ($urandom_range(0, 99) < 45);
      ut  = $urandom_range(0, 1) == 1;
      upr = $urandom_range(0, 1) == 1;
      li  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)) * 5;
      ui  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)) * 5;
      lpc = ($urandom() & 32'hFFFF_FF83) | (32'(li) << 2);
      upc = ($urandom() & 32'hFFFF_FF83) | (32'(ui) << 2);
      do_cycle(lv, lpc, uv, upc, ut, upr, r, pv, pd, ms);
    end

    // Drain, then compare every final counter's prediction with the model.
    idle(4);
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0, r, pv, pd, ms);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
